// File: rtl/counter_mode_top.sv
// Prescaled WIDTH-bit up/down counter with synchronous load, wrap/saturate/bounce overflow
// modes and a registered terminal-count pulse. Bounce mode is built only when COUNTER_BOUNCE_EN is defined.
module counter_mode_top #(
    parameter int unsigned      WIDTH     = 4,
    parameter int unsigned      DIV_W     = 27,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic [DIV_W-1:0] div_val,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] cnt_val,
    output logic             dir_out,
    output logic             tc
);
    localparam logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}};
    localparam logic [1:0]       MODE_SAT = 2'd1;

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic             tc_q, tc_d;
    logic             tick, step, bounce_mode, step_dir, at_limit;

    // >= rather than == so shrinking div_val below div_cnt ticks at once.
    assign tick = (div_cnt_q >= div_val);
    assign step = tick & enable & ~load;

`ifdef COUNTER_BOUNCE_EN
    localparam logic [1:0] MODE_BOUNCE = 2'd2;
    assign bounce_mode = (mode == MODE_BOUNCE);
`else
    assign bounce_mode = 1'b0;
`endif

    // In bounce mode the registered direction steers; otherwise the dir input does.
    assign step_dir = bounce_mode ? dir_q : dir;
    assign at_limit = step_dir ? (cnt_q == '0) : (cnt_q == MAX_VAL);

    always_comb begin
        div_cnt_d = (tick || load) ? '0 : div_cnt_q + 1'b1;
        cnt_d     = cnt_q;
        dir_d     = step_dir;
        tc_d      = 1'b0;
        if (load) begin
            cnt_d = load_val;
            dir_d = dir;
        end else if (step) begin
            if (!at_limit) begin
                cnt_d = step_dir ? cnt_q - 1'b1 : cnt_q + 1'b1;
            end else begin
                tc_d = 1'b1;
                if (mode == MODE_SAT) begin
                    cnt_d = cnt_q;
                end else if (bounce_mode) begin
                    cnt_d = step_dir ? cnt_q + 1'b1 : cnt_q - 1'b1;
                    dir_d = ~step_dir;
                end else begin
                    cnt_d = step_dir ? MAX_VAL : '0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt_q <= '0;
            cnt_q     <= RESET_VAL;
            dir_q     <= 1'b0;
            tc_q      <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            cnt_q     <= cnt_d;
            dir_q     <= dir_d;
            tc_q      <= tc_d;
        end
    end

    assign cnt_val = cnt_q;
    assign dir_out = dir_q;
    assign tc      = tc_q;
endmodule

// File: tb/tb_counter_mode_top.sv
// Self-checking bench for counter_mode_top: directed table, hand-written corner sequences,
// and randomized traffic against an arithmetic reference model.
module tb_counter_mode_top;
    localparam int WIDTH = 4;
    localparam int DIV_W = 27;
    localparam int MAXV  = (1 << WIDTH) - 1;
    localparam int EW    = WIDTH + 2;
`ifdef COUNTER_BOUNCE_EN
    localparam bit BOUNCE = 1'b1;
`else
    localparam bit BOUNCE = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset, enable, dir, load;
    logic [1:0]       mode;
    logic [DIV_W-1:0] div_val;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] cnt_val;
    logic             dir_out, tc;

    int checks   = 0;
    int failures = 0;
    logic [EW-1:0] exp_q[$];

    int m_cnt, m_div;
    bit m_dir, m_tc;

    typedef struct {
        logic en, dr, ld;
        logic [1:0] md;
        logic [WIDTH-1:0] lv;
        int e_cnt;
        bit e_dir, e_tc;
    } vec_t;
    vec_t vt[19];

    // clock / reset
    always #5 clk = ~clk;

    counter_mode_top #(.WIDTH(WIDTH), .DIV_W(DIV_W), .RESET_VAL('0)) dut (
        .clk(clk), .reset(reset), .enable(enable), .dir(dir), .mode(mode),
        .div_val(div_val), .load(load), .load_val(load_val),
        .cnt_val(cnt_val), .dir_out(dir_out), .tc(tc)
    );

    // reference model: counts as a plain integer and folds back into 0..MAXV by rule
    function automatic void model_reset();
        m_cnt = 0; m_div = 0; m_dir = 1'b0; m_tc = 1'b0;
    endfunction

    function automatic void model_edge();
        int delta, nxt;
        bit tk, bmode;
        if (reset) begin
            model_reset();
            return;
        end
        tk    = (m_div >= int'(div_val));
        bmode = BOUNCE && (mode == 2'd2);
        m_tc  = 1'b0;
        if (load) begin
            m_cnt = int'(load_val); m_div = 0; m_dir = dir;
            return;
        end
        m_div = tk ? 0 : m_div + 1;
        if (!bmode) m_dir = dir;
        if (tk && enable) begin
            delta = m_dir ? -1 : 1;
            nxt   = m_cnt + delta;
            if (nxt < 0 || nxt > MAXV) begin
                m_tc = 1'b1;
                if (mode == 2'd1) nxt = m_cnt;
                else if (bmode) begin
                    nxt   = m_cnt - delta;
                    m_dir = ~m_dir;
                end else nxt = (nxt + MAXV + 1) % (MAXV + 1);
            end
            m_cnt = nxt;
        end
    endfunction

    // scoreboard
    task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got cnt=%0d dir_out=%0b tc=%0b, expected cnt=%0d dir_out=%0b tc=%0b",
                     name, act[EW-1:2], act[1], act[0], exp[EW-1:2], exp[1], exp[0]);
        end
    endtask

    task automatic chk_val(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // driver: one clock edge, model updated alongside, DUT compared on the falling edge
    task automatic cycle(input string name);
        logic [EW-1:0] e;
        logic [WIDTH-1:0] mc;
        @(posedge clk);
        model_edge();
        mc = m_cnt[WIDTH-1:0];
        exp_q.push_back({mc, m_dir, m_tc});
        @(negedge clk);
        e = exp_q.pop_front();
        chk(name, {cnt_val, dir_out, tc}, e);
    endtask

    task automatic set_in(input logic en, input logic dr, input logic [1:0] md,
                          input logic ld, input logic [WIDTH-1:0] lv);
        enable = en; dir = dr; mode = md; load = ld; load_val = lv;
    endtask

    task automatic do_load(input logic [WIDTH-1:0] lv, input logic dr, input logic [1:0] md);
        set_in(1'b1, dr, md, 1'b1, lv);
        cycle("load");
        load = 1'b0;
    endtask

    function automatic vec_t mk(input logic en, input logic dr, input logic [1:0] md,
                                input logic ld, input logic [WIDTH-1:0] lv,
                                input int c, input bit d, input bit t);
        vec_t v;
        v.en = en; v.dr = dr; v.md = md; v.ld = ld; v.lv = lv;
        v.e_cnt = c; v.e_dir = d; v.e_tc = t;
        return v;
    endfunction

    initial begin
        int tc_count;
        logic [WIDTH-1:0] ecnt;

        reset = 1'b1;
        set_in(1'b0, 1'b0, 2'd0, 1'b0, '0);
        div_val = '0;
        model_reset();
        #1;
        chk("reset_values", {cnt_val, dir_out, tc}, '0);
        cycle("in_reset");
        cycle("in_reset");
        reset = 1'b0;

        // directed table, div_val = 0 so every enabled cycle steps
        vt[0]  = mk(1, 0, 2'd0, 1, 4'd14, 14, 0, 0);
        vt[1]  = mk(1, 0, 2'd0, 0, 4'd0,  15, 0, 0);
        vt[2]  = mk(1, 0, 2'd0, 0, 4'd0,   0, 0, 1);
        vt[3]  = mk(1, 1, 2'd0, 1, 4'd1,   1, 1, 0);
        vt[4]  = mk(1, 1, 2'd0, 0, 4'd0,   0, 1, 0);
        vt[5]  = mk(1, 1, 2'd0, 0, 4'd0,  15, 1, 1);
        vt[6]  = mk(1, 0, 2'd1, 1, 4'd13, 13, 0, 0);
        vt[7]  = mk(1, 0, 2'd1, 0, 4'd0,  14, 0, 0);
        vt[8]  = mk(1, 0, 2'd1, 0, 4'd0,  15, 0, 0);
        vt[9]  = mk(1, 0, 2'd1, 0, 4'd0,  15, 0, 1);
        vt[10] = mk(1, 0, 2'd1, 0, 4'd0,  15, 0, 1);
        vt[11] = mk(1, 1, 2'd1, 1, 4'd1,   1, 1, 0);
        vt[12] = mk(1, 1, 2'd1, 0, 4'd0,   0, 1, 0);
        vt[13] = mk(1, 1, 2'd1, 0, 4'd0,   0, 1, 1);
        vt[14] = mk(1, 0, 2'd2, 1, 4'd13, 13, 0, 0);
        vt[15] = mk(1, 0, 2'd2, 0, 4'd0,  14, 0, 0);
        vt[16] = mk(1, 0, 2'd2, 0, 4'd0,  15, 0, 0);
        vt[17] = mk(1, 0, 2'd2, 0, 4'd0, BOUNCE ? 14 : 0, BOUNCE, 1);
        vt[18] = mk(1, 0, 2'd2, 0, 4'd0, BOUNCE ? 13 : 1, BOUNCE, 0);
        div_val = '0;
        for (int i = 0; i < 19; i++) begin
            set_in(vt[i].en, vt[i].dr, vt[i].md, vt[i].ld, vt[i].lv);
            cycle("table_model");
            ecnt = vt[i].e_cnt[WIDTH-1:0];
            chk($sformatf("table_%0d", i), {cnt_val, dir_out, tc}, {ecnt, vt[i].e_dir, vt[i].e_tc});
        end
        load = 1'b0;

        // reset mid-run: one step per 4 cycles, async reset at cnt_val = 5
        div_val = 27'd3;
        do_load(4'd0, 1'b0, 2'd0);
        for (int i = 0; i < 3; i++) cycle("period_hold");
        chk_val("period_hold_val", int'(cnt_val), 0);
        cycle("period_step");
        chk_val("period_first_step", int'(cnt_val), 1);
        for (int i = 0; i < 16; i++) cycle("run_to_5");
        chk_val("reached_5", int'(cnt_val), 5);
        #2 reset = 1'b1;
        #1;
        model_reset();
        chk("async_reset", {cnt_val, dir_out, tc}, '0);
        cycle("held_reset");
        reset = 1'b0;

        // load collides with tick: load wins, next step three cycles later
        div_val = 27'd2;
        do_load(4'd0, 1'b0, 2'd0);
        cycle("pre_collide");
        cycle("pre_collide");
        set_in(1'b1, 1'b0, 2'd0, 1'b1, 4'd9);
        cycle("collide");
        chk("collide_load", {cnt_val, dir_out, tc}, {4'd9, 1'b0, 1'b0});
        load = 1'b0;
        cycle("post_collide");
        cycle("post_collide");
        chk_val("collide_no_early_step", int'(cnt_val), 9);
        cycle("post_collide");
        chk_val("collide_step_3", int'(cnt_val), 10);

        // div_val shrink below the running prescale count
        for (int pass = 0; pass < 2; pass++) begin
            div_val = 27'd100;
            do_load(4'd3, 1'b0, 2'd0);
            enable = (pass == 0);
            tc_count = 0;
            for (int i = 0; i < 20; i++) cycle("shrink_wait");
            div_val = 27'd5;
            cycle("shrink_tick");
            chk_val($sformatf("shrink_immediate_%0d", pass), int'(cnt_val), pass == 0 ? 4 : 3);
            for (int i = 0; i < 6; i++) begin
                cycle("shrink_period");
                tc_count += int'(tc);
                if (i == 4) chk_val($sformatf("shrink_hold_%0d", pass), int'(cnt_val), pass == 0 ? 4 : 3);
            end
            chk_val($sformatf("shrink_period6_%0d", pass), int'(cnt_val), pass == 0 ? 5 : 3);
            chk_val($sformatf("shrink_no_tc_%0d", pass), tc_count, 0);
        end

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            enable   = ($urandom_range(0, 3) != 0);
            dir      = $urandom_range(0, 1);
            mode     = 2'($urandom_range(0, 3));
            div_val  = 27'($urandom_range(0, 3));
            load     = ($urandom_range(0, 15) == 0);
            load_val = 4'($urandom_range(0, MAXV));
            if ($urandom_range(0, 7) != 0 && i > 0) begin
                dir  = ~dir | dir;
            end
            cycle("random");
        end

        if (exp_q.size() != 0) chk_val("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/counter_mode_top.md
# counter_mode_top

Parametrised successor of the LED counter top: a free-running prescaler with a runtime-programmable divide value drives a WIDTH-bit up/down counter. Adds synchronous load, three overflow modes (wrap, saturate, bounce) and a registered terminal-count pulse. It sits between board controls (buttons and switches) and the LED bank, and can also be instantiated as a generic slow event counter.

## Interface
- WIDTH, 4: counter width; legal range 2..32.
- DIV_W, 27: prescaler width; legal range 1..32.
- RESET_VAL, 0: counter value after reset; must fit in WIDTH bits.
- clk  in  1  single clock for the whole block.
- reset  in  1  asynchronous, active-high reset; clears all state immediately and is released synchronously to clk.
- enable  in  1  step permission; prescaler runs regardless.
- dir  in  1  0 = count up, 1 = count down.
- mode  in  2  0 wrap, 1 saturate, 2 bounce, 3 treated as wrap.
- div_val  in  DIV_W  prescaler terminal value; step period = div_val+1 clk cycles.
- load  in  1  synchronous load strobe.
- load_val  in  WIDTH  value written on load.
- cnt_val  out  WIDTH  counter value, drives LEDs; registered.
- dir_out  out  1  effective direction currently applied; registered.
- tc  out  1  one-cycle terminal-count pulse; registered.

## Operation
- Prescaler div_cnt (DIV_W bits): internal strobe tick = (div_cnt >= div_val). On tick, div_cnt <= 0; otherwise div_cnt <= div_cnt+1. The >= compare makes lowering div_val below the current div_cnt give an immediate tick, never a 2^DIV_W wait.
- A step occurs when tick & enable & ~load.
- Priority, highest first: reset, load, step, hold.
- Load: cnt_val <= load_val, div_cnt <= 0, dir_out <= dir, tc <= 0.
- Effective direction: in modes 0, 1 and 3, dir_out <= dir every cycle. In mode 2, dir_out is owned by the bounce logic and dir is ignored, except on load.
- Let MAX = 2^WIDTH-1. Step behaviour, up direction:
  - Mode 0 (and 3): MAX -> 0, tc.
  - Mode 1: at MAX, hold, tc.
  - Mode 2: at MAX, go to MAX-1, dir_out <= 1, tc.
  - Otherwise: +1, no tc.
- Down direction mirrors this: mode 0 gives 0 -> MAX with tc; mode 1 holds at 0 with tc; mode 2 goes 0 -> 1 with dir_out <= 0 and tc; otherwise -1.
- Switching into mode 2 keeps the current dir_out as the starting bounce direction.
- Arithmetic is modulo 2^WIDTH. div_val = 0 makes tick true every cycle.

## Timing
- Reset values: cnt_val = RESET_VAL, dir_out = 0, tc = 0, div_cnt = 0.
- cnt_val changes on the clk edge where the step is true: 0 cycles after tick, registered.
- tc is high for exactly the one cycle following the step edge that caused the terminal event. Back-to-back terminal steps with div_val = 0 give tc high on consecutive cycles.
- First step after reset release or after load occurs div_val+1 cycles later, provided enable is held high.
- Load and tick in the same cycle: load wins, no step, no tc.
- Changing dir or mode takes effect on the next step edge. A change of div_val is sampled by every compare.
- Reset asserted mid-count: outputs take their reset values asynchronously, without waiting for clk.

## Configuration
- COUNTER_BOUNCE_EN defined: mode 2 behaves as bounce, as specified above.
- COUNTER_BOUNCE_EN undefined: bounce logic is removed, mode 2 behaves exactly as mode 0 (wrap), and dir_out always follows dir.

## Test plan
- Reset mid-run: WIDTH=4, div_val=3, enable=1, dir=0, mode=0 -> cnt_val increments every 4 cycles. Reset asserted at cnt_val=5 -> cnt_val=0 and tc=0 immediately, without a clk edge.
- Wrap both ways: div_val=0, mode=0, load_val=14 -> sequence 15, 0 with tc on the cycle after 15 -> 0. With dir=1 from 1: 0, 15 with tc.
- Saturate: mode=1, dir=0, load 13, div_val=0 -> 14, 15, 15, 15 with tc on every cycle after a step at 15. dir=1 from 1 -> 0, 0 with tc.
- Bounce (macro defined): mode=2, load 13, dir=0, div_val=0 -> 14, 15, 14, 13, and dir_out goes 0 -> 1 one cycle after the 15 step. Same stimulus with the macro undefined -> 14, 15, 0, 1.
- Load vs tick collision: div_val=2, load asserted on a tick cycle with load_val=9 -> cnt_val=9, no tc, next step exactly 3 cycles later.
- div_val shrink: div_cnt=20, div_val changed 100 -> 5 -> tick next cycle, then period 6. With enable=0 -> cnt_val unchanged and tc stays 0 throughout.
